// File: rtl/sysarr_output_collector_if.sv
// Row capture and writeback handshake bundle for
// the systolic array output collector.
interface sysarr_output_collector_if #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int TILE_W = 8
);
  logic                  out_en;
  logic [$clog2(N)-1:0]  row_out;
  logic [DW*N-1:0]       array_output;
  logic                  wr_valid;
  logic                  wr_ready;
  logic [$clog2(N)-1:0]  wr_row;
  logic [TILE_W-1:0]     wr_tile;
  logic [DW*N-1:0]       wr_data;

  modport master (
    output out_en, row_out, array_output, wr_ready,
    input  wr_valid, wr_row, wr_tile, wr_data
  );

  modport slave (
    input  out_en, row_out, array_output, wr_ready,
    output wr_valid, wr_row, wr_tile, wr_data
  );
endinterface

// File: rtl/sysarr_output_collector.sv
// Buffers non-stallable systolic array rows and replays
// them to writeback with row/tile tags.
module sysarr_output_collector #(
  parameter int N      = 4,
  parameter int DW     = 16,
  parameter int DEPTH  = 8,
  parameter int TILE_W = 8
) (
  input  logic                     clk,
  input  logic                     nRST,
  sysarr_output_collector_if.slave bus,
  input  logic                     drained,
  output logic                     tile_done,
  output logic                     credit_ok,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     seq_err,
  output logic                     idle
);
  localparam int RW = $clog2(N);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [RW-1:0]   row;
    logic [DW*N-1:0] data;
  } entry_t;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    TILE_END
  } state_t;

  entry_t          mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [RW-1:0]   exp_row;
  logic [TILE_W-1:0] tile_q;
  logic [CW-1:0]   count_d;
  state_t          state_q;
  state_t          state_d;

  logic full;
  logic push;
  logic pop;
  logic accept;
  logic last_pop;
  entry_t head;

  assign head     = mem[rd_ptr];
  assign full     = (count == CW'(DEPTH));
  assign push     = bus.out_en;
  assign pop      = bus.wr_valid && bus.wr_ready;
  // A full FIFO still takes a row when the head leaves this cycle
  assign accept   = push && (!full || pop);
  assign last_pop = pop && (head.row == RW'(N - 1));

  assign bus.wr_valid = (count != '0);
  assign bus.wr_data  = bus.wr_valid ? head.data : '0;
  assign bus.wr_row   = bus.wr_valid ? head.row : '0;
  assign bus.wr_tile  = tile_q;

  assign credit_ok = (count <= CW'(DEPTH - N));
  assign idle      = drained && (count == '0);
  assign tile_done = (state_q == TILE_END);

  always_comb begin
    count_d = count;
    if (accept && !pop)
      count_d = count + CW'(1);
    else if (pop && !accept)
      count_d = count - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!nRST && accept)
      mem[wr_ptr] <= '{row: bus.row_out,
                       data: bus.array_output};
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      exp_row  <= '0;
      tile_q   <= '0;
      overflow <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      count <= count_d;
      if (accept)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      if (push && full && !pop)
        overflow <= 1'b1;
      // Resync to the received row so one slip flags once
      if (accept) begin
        if (bus.row_out != exp_row)
          seq_err <= 1'b1;
        exp_row <= (bus.row_out == RW'(N - 1)) ?
                   '0 : bus.row_out + RW'(1);
      end
      if (last_pop)
        tile_q <= tile_q + TILE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (nRST)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (count_d != '0)
          state_d = SEND;
      end
      SEND: begin
        if (last_pop)
          state_d = TILE_END;
        else if (count_d == '0)
          state_d = IDLE;
      end
      TILE_END: begin
        if (last_pop)
          state_d = TILE_END;
        else if (count_d != '0)
          state_d = SEND;
        else
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sysarr_output_collector.sv
// Directed scoreboard bench for the systolic array
// output collector.
module tb_sysarr_output_collector;
  localparam int N      = 4;
  localparam int DW     = 16;
  localparam int DEPTH  = 8;
  localparam int TILE_W = 8;

  typedef struct packed {
    logic [1:0]  row;
    logic [7:0]  tile;
    logic [63:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       nRST;
  logic       drained;
  logic       tile_done;
  logic       credit_ok;
  logic [3:0] count;
  logic       overflow;
  logic       seq_err;
  logic       idle;

  sysarr_output_collector_if #(
    .N(N), .DW(DW), .TILE_W(TILE_W)
  ) bus ();

  sysarr_output_collector #(
    .N(N), .DW(DW), .DEPTH(DEPTH), .TILE_W(TILE_W)
  ) dut (
    .clk       (clk),
    .nRST      (nRST),
    .bus       (bus),
    .drained   (drained),
    .tile_done (tile_done),
    .credit_ok (credit_ok),
    .count     (count),
    .overflow  (overflow),
    .seq_err   (seq_err),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  exp_t       q[$];
  int         n_assert = 0;
  int         n_fail   = 0;
  int         mcount   = 0;
  logic [7:0] ptile    = '0;
  logic       etdone   = 1'b0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  // Compare state, score any handshake, then advance one clock
  task automatic step();
    logic pop;
    exp_t e;
    #1;
    chk("count", 64'(count), 64'(mcount));
    chk("sb_size", 64'(q.size()), 64'(mcount));
    chk("wr_valid", 64'(bus.wr_valid), 64'(mcount != 0));
    chk("tile_done", 64'(tile_done), 64'(etdone));
    chk("idle", 64'(idle), 64'(drained && mcount == 0));
    chk("credit_ok", 64'(credit_ok), 64'(mcount <= DEPTH - N));
    if (mcount == 0)
      chk("wr_data_zero", bus.wr_data, 64'h0);
    pop = (mcount != 0) && bus.wr_ready;
    etdone = 1'b0;
    if (nRST) begin
      q.delete();
      mcount = 0;
      ptile = '0;
    end else begin
      if (mcount != 0 && q.size() != 0) begin
        e = q[0];
        chk("wr_row", 64'(bus.wr_row), 64'(e.row));
        chk("wr_tile", 64'(bus.wr_tile), 64'(e.tile));
        chk("wr_data", bus.wr_data, e.data);
        if (pop) begin
          void'(q.pop_front());
          etdone = (e.row == 2'd3);
        end
      end
      if (bus.out_en && (mcount < DEPTH || pop)) begin
        e.row  = bus.row_out;
        e.tile = ptile;
        e.data = bus.array_output;
        q.push_back(e);
        if (bus.row_out == 2'd3)
          ptile++;
        if (!pop)
          mcount++;
      end else if (pop) begin
        mcount--;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push_row(input logic [1:0] r,
                          input logic [63:0] d);
    bus.out_en       = 1'b1;
    bus.row_out      = r;
    bus.array_output = d;
    step();
    bus.out_en = 1'b0;
  endtask

  initial begin
    nRST             = 1'b1;
    drained          = 1'b0;
    bus.out_en       = 1'b0;
    bus.row_out      = '0;
    bus.array_output = '0;
    bus.wr_ready     = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nRST = 1'b0;
    #1;
    chk("rst_valid", 64'(bus.wr_valid), 64'h0);
    chk("rst_data", bus.wr_data, 64'h0);
    chk("rst_row", 64'(bus.wr_row), 64'h0);
    chk("rst_tile", 64'(bus.wr_tile), 64'h0);
    chk("rst_credit", 64'(credit_ok), 64'h1);
    chk("rst_idle", 64'(idle), 64'(drained));
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_ovf", 64'(overflow), 64'h0);
    chk("rst_seq", 64'(seq_err), 64'h0);

    // Streaming tile
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      push_row(2'(i), {4{16'(16'h1111 * (i + 1))}});
    step();
    step();
    chk("stream_tile", 64'(bus.wr_tile), 64'h1);
    chk("stream_ovf", 64'(overflow), 64'h0);
    chk("stream_seq", 64'(seq_err), 64'h0);

    // Backpressure fill
    bus.wr_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_row(2'(i % 4), {4{16'(16'hA000 + i)}});
      if (i == 3)
        chk("credit_at4", 64'(credit_ok), 64'h1);
      if (i == 4)
        chk("credit_at5", 64'(credit_ok), 64'h0);
    end
    chk("full_count", 64'(count), 64'h8);
    chk("full_ovf", 64'(overflow), 64'h0);

    // Full with simultaneous pop
    bus.wr_ready = 1'b1;
    push_row(2'd0, {4{16'hC0C0}});
    chk("fullpop_count", 64'(count), 64'h8);
    chk("fullpop_ovf", 64'(overflow), 64'h0);

    // Full without pop drops the row
    bus.wr_ready = 1'b0;
    push_row(2'd1, {4{16'hDEAD}});
    chk("drop_ovf", 64'(overflow), 64'h1);
    chk("drop_count", 64'(count), 64'h8);
    bus.wr_ready = 1'b1;
    repeat (10) step();
    chk("drain_seq", 64'(seq_err), 64'h0);
    chk("drain_ovf_sticky", 64'(overflow), 64'h1);

    // Reset mid-operation
    bus.wr_ready = 1'b0;
    push_row(2'd1, {4{16'h5001}});
    push_row(2'd2, {4{16'h5002}});
    push_row(2'd3, {4{16'h5003}});
    nRST = 1'b1;
    step();
    nRST = 1'b0;
    #1;
    chk("mrst_valid", 64'(bus.wr_valid), 64'h0);
    chk("mrst_count", 64'(count), 64'h0);
    chk("mrst_tile", 64'(bus.wr_tile), 64'h0);
    chk("mrst_ovf", 64'(overflow), 64'h0);
    chk("mrst_seq", 64'(seq_err), 64'h0);
    chk("mrst_credit", 64'(credit_ok), 64'h1);

    // Out-of-order rows
    push_row(2'd0, {4{16'h7000}});
    push_row(2'd1, {4{16'h7001}});
    chk("ooo_seq_ok", 64'(seq_err), 64'h0);
    push_row(2'd3, {4{16'h7003}});
    chk("ooo_seq_err", 64'(seq_err), 64'h1);
    push_row(2'd0, {4{16'h7010}});
    bus.wr_ready = 1'b1;
    repeat (6) step();
    chk("ooo_tile", 64'(bus.wr_tile), 64'h1);

    // Idle tracking
    drained = 1'b1;
    step();
    chk("idle_empty", 64'(idle), 64'h1);
    bus.wr_ready = 1'b0;
    push_row(2'd1, {4{16'h9001}});
    chk("idle_busy", 64'(idle), 64'h0);
    bus.wr_ready = 1'b1;
    step();
    step();
    chk("idle_again", 64'(idle), 64'h1);
    drained = 1'b0;
    #1;
    chk("idle_undrained", 64'(idle), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/sysarr_output_collector.md
Name: sysarr_output_collector

Overview:
- Downstream neighbour of the systolic array.
- Captures every result row the array emits (out_en / row_out / array_output) into an internal FIFO, because the array cannot stall its output.
- Replays the rows to the memory/writeback side over a valid/ready handshake, tagging each row with its index and tile number.
- Reports tile completion, buffer credit for upstream throttling, and sticky overflow/sequence errors.

Parameters:
- N, 4, array dimension; rows per tile and elements per row.
- DW, 16, element width in bits.
- DEPTH, 8, FIFO depth in rows; power of two, >= N.
- TILE_W, 8, width of the tile counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- nRST  in  1  reset; synchronous, active-high (1 = reset).
- out_en  in  1  array output row valid; single-cycle, no backpressure.
- row_out  in  $clog2(N)  index of the emitted row.
- array_output  in  DW*N  row data.
- drained  in  1  array reports no work in flight.
- wr_valid  out  1  head row available.
- wr_ready  in  1  writeback accepts the head row.
- wr_row  out  $clog2(N)  row index of the head entry.
- wr_tile  out  TILE_W  tile number of the head entry.
- wr_data  out  DW*N  head row data.
- tile_done  out  1  one-cycle pulse after the last row of a tile is written.
- credit_ok  out  1  room for a full tile: count <= DEPTH-N.
- count  out  $clog2(DEPTH)+1  rows currently buffered.
- overflow  out  1  sticky; a row was dropped.
- seq_err  out  1  sticky; row arrived out of order.
- idle  out  1  drained && FIFO empty.

Behaviour:
- Reset (nRST=1 at a rising edge):
  - Clears rd_ptr, wr_ptr, count, exp_row, the tile counter, overflow, seq_err and tile_done.
  - After reset: wr_valid=0, wr_data=0, wr_row=0, wr_tile=0, credit_ok=1, idle=drained.
  - Reset mid-operation discards all buffered rows. No partial handshake survives.
- Push: push = out_en.
  - When not full, the entry {row_out, array_output} is written at wr_ptr. wr_ptr wraps DEPTH-1 -> 0.
  - When full and there is no pop in the same cycle, the row is discarded and overflow <= 1.
  - When full with a simultaneous pop, the row is accepted and count is unchanged.
- Pop: pop = wr_valid && wr_ready.
  - wr_valid = (count != 0). The FIFO is first-word-fall-through.
  - A row pushed at edge t is visible on wr_valid/wr_data from cycle t+1. There is no bypass when empty.
  - wr_data, wr_row and wr_tile hold stable while wr_valid && !wr_ready.
  - wr_data is forced to 0 when wr_valid=0.
  - rd_ptr wraps DEPTH-1 -> 0.
- count: +1 on an accepted push only, -1 on a pop only, unchanged on both or neither.
- Sequence check (accepted pushes only):
  - If row_out != exp_row, seq_err <= 1.
  - exp_row <= row_out+1, wrapping N-1 -> 0, so the check resyncs to the received row.
  - The row is stored regardless of the check result.
- Tile tracking (write side):
  - The tile counter tile_q drives wr_tile.
  - On a pop with wr_row == N-1: tile_q <= tile_q+1 (wraps at 2^TILE_W) and tile_done <= 1 for exactly one cycle.
  - All other cycles: tile_done <= 0.
- Write-side FSM, IDLE / SEND / TILE_END:
  - IDLE: count==0. Goes to SEND when count != 0.
  - SEND: wr_valid=1. Goes to TILE_END on a pop of row N-1. Goes to IDLE when the FIFO empties after another row.
  - TILE_END: tile_done=1 for one cycle. Goes to SEND if count != 0, else IDLE.
  - Pops remain legal in TILE_END.
- credit_ok and idle are combinational from the registered count, credit_ok also from the DEPTH parameter, and idle also from drained.
- Sticky flags clear only on reset.

Test Plan:
- Streaming tile (N=4, DEPTH=8, wr_ready=1): pushes rows 0..3 with data 0x1111..., 0x2222..., 0x3333..., 0x4444... on consecutive cycles -> four writes in order, wr_row 0..3, wr_tile=0. tile_done pulses one cycle after the row-3 handshake, then wr_tile=1. overflow=0, seq_err=0.
- Backpressure (wr_ready=0): push 9 rows -> credit_ok drops when count reaches 5; count saturates at 8; 9th row dropped; overflow=1. Raising wr_ready drains rows 1..8 in order; the 9th row's data never appears.
- Full with simultaneous pop (count=8, wr_ready=1, out_en=1) -> new row accepted, count stays 8, overflow stays 0.
- Out-of-order rows: sequence 0,1,3 -> seq_err=1 on the third push; the next push of row 0 raises no new error; all three rows are still written out.
- Reset mid-operation: 3 rows buffered, nRST=1 for one cycle -> next cycle wr_valid=0, count=0, wr_tile=0, flags=0, credit_ok=1; the next push of row 0 starts a fresh tile.
- Idle: drained=1 with the FIFO empty -> idle=1. A push takes idle to 0 until the FIFO empties. drained=0 forces idle=0.
